// File: rtl/dmem_apb_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_apb_arbiter_if: requester handshakes and APB bus of the DMEM arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface dmem_apb_arbiter_if #(
  parameter int DAT_W  = 32,
  parameter int ADDR_W = 32
);
  localparam int STRB_W = DAT_W / 8;

  logic              r0_req_i;
  logic              r0_write_i;
  logic [ADDR_W-1:0] r0_addr_i;
  logic [DAT_W-1:0]  r0_wdata_i;
  logic [STRB_W-1:0] r0_strb_i;
  logic              r0_gnt_o;
  logic              r0_rvalid_o;
  logic [DAT_W-1:0]  r0_rdata_o;
  logic              r0_err_o;

  logic              r1_req_i;
  logic              r1_write_i;
  logic [ADDR_W-1:0] r1_addr_i;
  logic [DAT_W-1:0]  r1_wdata_i;
  logic [STRB_W-1:0] r1_strb_i;
  logic              r1_gnt_o;
  logic              r1_rvalid_o;
  logic [DAT_W-1:0]  r1_rdata_o;
  logic              r1_err_o;

  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [ADDR_W-1:0] paddr_o;
  logic [DAT_W-1:0]  pwdata_o;
  logic [STRB_W-1:0] pstrb_o;
  logic [DAT_W-1:0]  prdata_i;
  logic              pready_i;
  logic              pslverr_i;

  // Arbiter side.
  modport slave (
    input  r0_req_i, r0_write_i, r0_addr_i, r0_wdata_i, r0_strb_i,
    output r0_gnt_o, r0_rvalid_o, r0_rdata_o, r0_err_o,
    input  r1_req_i, r1_write_i, r1_addr_i, r1_wdata_i, r1_strb_i,
    output r1_gnt_o, r1_rvalid_o, r1_rdata_o, r1_err_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
    input  prdata_i, pready_i, pslverr_i
  );

  // Requesters plus APB completer side.
  modport master (
    output r0_req_i, r0_write_i, r0_addr_i, r0_wdata_i, r0_strb_i,
    input  r0_gnt_o, r0_rvalid_o, r0_rdata_o, r0_err_o,
    output r1_req_i, r1_write_i, r1_addr_i, r1_wdata_i, r1_strb_i,
    input  r1_gnt_o, r1_rvalid_o, r1_rdata_o, r1_err_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
    output prdata_i, pready_i, pslverr_i
  );
endinterface
`default_nettype wire

// File: rtl/dmem_apb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_apb_arbiter: two-requester round-robin arbiter and APB phase sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
module dmem_apb_arbiter #(
  parameter int DAT_W       = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input logic               clk,
  input logic               rst,
  dmem_apb_arbiter_if.slave bus
);
  localparam int STRB_W = DAT_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DAT_W-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;
  logic [DAT_W-1:0]  rdata_q, rdata_d;
  logic              err_q, err_d;

  logic w_idle, w_gnt0, w_gnt1, w_timeout, w_done;
  logic w_psel, w_penable;

  // Grants are combinational, so they are masked while reset is held.
  assign w_idle    = (state_q == S_IDLE) && !rst;
  assign w_gnt0    = w_idle && bus.r0_req_i && (!bus.r1_req_i || last_gnt_q);
  assign w_gnt1    = w_idle && bus.r1_req_i && (!bus.r0_req_i || !last_gnt_q);
  assign w_timeout = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);
  assign w_done    = (state_q == S_ACCESS) && (bus.pready_i || w_timeout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (w_gnt0 || w_gnt1) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (w_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
    w_penable = (state_q == S_ACCESS);
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    cnt_d      = cnt_q;
    rv0_d      = 1'b0;
    rv1_d      = 1'b0;
    rdata_d    = '0;
    err_d      = 1'b0;
    if (w_gnt0 || w_gnt1) begin
      owner_d    = w_gnt1;
      last_gnt_d = w_gnt1;
      wr_d       = w_gnt1 ? bus.r1_write_i : bus.r0_write_i;
      addr_d     = w_gnt1 ? bus.r1_addr_i  : bus.r0_addr_i;
      wdata_d    = w_gnt1 ? bus.r1_wdata_i : bus.r0_wdata_i;
      strb_d     = w_gnt1 ? bus.r1_strb_i  : bus.r0_strb_i;
    end
    if (state_q == S_SETUP) cnt_d = '0;
    if ((state_q == S_ACCESS) && !bus.pready_i) cnt_d = cnt_q + CNT_W'(1);
    // A ready response in the timeout cycle takes precedence over the abort.
    if (w_done) begin
      rv0_d   = !owner_q;
      rv1_d   = owner_q;
      rdata_d = (bus.pready_i && !wr_q) ? bus.prdata_i : '0;
      err_d   = bus.pready_i ? bus.pslverr_i : 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      cnt_q      <= '0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      cnt_q      <= cnt_d;
      rv0_q      <= rv0_d;
      rv1_q      <= rv1_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.r0_gnt_o    = w_gnt0;
  assign bus.r1_gnt_o    = w_gnt1;
  assign bus.r0_rvalid_o = rv0_q;
  assign bus.r1_rvalid_o = rv1_q;
  assign bus.r0_rdata_o  = rv0_q ? rdata_q : '0;
  assign bus.r1_rdata_o  = rv1_q ? rdata_q : '0;
  assign bus.r0_err_o    = rv0_q && err_q;
  assign bus.r1_err_o    = rv1_q && err_q;
  assign bus.psel_o      = w_psel;
  assign bus.penable_o   = w_penable;
  assign bus.pwrite_o    = wr_q;
  assign bus.paddr_o     = addr_q;
  assign bus.pwdata_o    = wdata_q;
  assign bus.pstrb_o     = strb_q;
endmodule
`default_nettype wire

// File: tb/tb_dmem_apb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_apb_arbiter: self-checking bench for dmem_apb_arbiter. Rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_apb_arbiter;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  dmem_apb_arbiter_if #(.DAT_W(32), .ADDR_W(32)) bus ();

  dmem_apb_arbiter #(.DAT_W(32), .ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // APB completer configuration for the current transfer(s).
  int          wait_n = 0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_data = 32'h0;
  int          acc_k = 0;

  // Event logs observed on the bus.
  int          g_cyc[$];
  int          g_id[$];
  int          v_cyc[$];
  int          v_id[$];
  logic [31:0] v_data[$];
  logic        v_err[$];
  logic        v_psel[$];
  int          s_cyc[$];
  logic [31:0] s_addr[$];
  logic [31:0] s_wdata[$];
  logic        s_wr[$];
  logic [3:0]  s_strb[$];
  int          inv_bad = 0;
  logic [31:0] c_addr = 32'h0;
  logic [31:0] c_wdata = 32'h0;
  logic        c_wr = 1'b0;
  logic [3:0]  c_strb = 4'h0;

  always @(negedge clk) begin
    if (bus.r0_gnt_o) begin g_cyc.push_back(cyc); g_id.push_back(0); end
    if (bus.r1_gnt_o) begin g_cyc.push_back(cyc); g_id.push_back(1); end
    if (bus.r0_rvalid_o) begin
      v_cyc.push_back(cyc); v_id.push_back(0); v_data.push_back(bus.r0_rdata_o);
      v_err.push_back(bus.r0_err_o); v_psel.push_back(bus.psel_o);
    end
    if (bus.r1_rvalid_o) begin
      v_cyc.push_back(cyc); v_id.push_back(1); v_data.push_back(bus.r1_rdata_o);
      v_err.push_back(bus.r1_err_o); v_psel.push_back(bus.psel_o);
    end
    if (bus.r0_rvalid_o && bus.r1_rvalid_o) inv_bad++;
    if (!bus.r0_rvalid_o && (bus.r0_rdata_o != 0 || bus.r0_err_o)) inv_bad++;
    if (!bus.r1_rvalid_o && (bus.r1_rdata_o != 0 || bus.r1_err_o)) inv_bad++;
    if (bus.penable_o && !bus.psel_o) inv_bad++;
    // APB fields must be frozen from SETUP onwards and hold through IDLE.
    if (rst) begin
      c_addr = 0; c_wdata = 0; c_wr = 0; c_strb = 0;
    end else if (bus.psel_o && !bus.penable_o) begin
      c_addr = bus.paddr_o; c_wdata = bus.pwdata_o; c_wr = bus.pwrite_o; c_strb = bus.pstrb_o;
      s_cyc.push_back(cyc); s_addr.push_back(c_addr); s_wdata.push_back(c_wdata);
      s_wr.push_back(c_wr); s_strb.push_back(c_strb);
    end else if ({bus.paddr_o, bus.pwdata_o, bus.pwrite_o, bus.pstrb_o} !== {c_addr, c_wdata, c_wr, c_strb}) begin
      inv_bad++;
    end
    if (bus.psel_o && bus.penable_o) begin
      bus.pready_i = (acc_k >= wait_n);
      acc_k++;
    end else begin
      bus.pready_i = 1'b0;
      acc_k = 0;
    end
    bus.pslverr_i = bus.pready_i ? slv_err : 1'($urandom_range(0, 1));
    bus.prdata_i  = bus.pready_i ? slv_data : $urandom;
  end

  task automatic clear_logs();
    g_cyc.delete(); g_id.delete();
    v_cyc.delete(); v_id.delete(); v_data.delete(); v_err.delete(); v_psel.delete();
    s_cyc.delete(); s_addr.delete(); s_wdata.delete(); s_wr.delete(); s_strb.delete();
    inv_bad = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    clear_logs();
  endtask

  // Raise a request, hold it until granted, then drop it.
  task automatic send(input int id, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] st);
    logic got = 1'b0;
    @(posedge clk); #1;
    if (id == 0) begin
      bus.r0_write_i = wr; bus.r0_addr_i = a; bus.r0_wdata_i = wd; bus.r0_strb_i = st; bus.r0_req_i = 1'b1;
    end else begin
      bus.r1_write_i = wr; bus.r1_addr_i = a; bus.r1_wdata_i = wd; bus.r1_strb_i = st; bus.r1_req_i = 1'b1;
    end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = (id == 0) ? bus.r0_gnt_o : bus.r1_gnt_o;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL send_gnt r%0d got no grant within 100 cycles", id); end
    @(posedge clk); #1;
    if (id == 0) bus.r0_req_i = 1'b0; else bus.r1_req_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.r0_req_i = 1'b1; bus.r1_req_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({bus.r0_gnt_o, bus.r1_gnt_o} !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", {bus.r0_gnt_o, bus.r1_gnt_o}); end
    checks++; if ({bus.psel_o, bus.penable_o, bus.pwrite_o} !== 3'b000) begin errors++; $display("FAIL reset_ctl got %b want 000", {bus.psel_o, bus.penable_o, bus.pwrite_o}); end
    checks++; if (bus.paddr_o !== 32'h0) begin errors++; $display("FAIL reset_paddr got %h want 0", bus.paddr_o); end
    checks++; if ({bus.pwdata_o, bus.pstrb_o} !== 36'h0) begin errors++; $display("FAIL reset_pwdata got %h want 0", {bus.pwdata_o, bus.pstrb_o}); end
    checks++; if ({bus.r0_rvalid_o, bus.r1_rvalid_o, bus.r0_err_o, bus.r1_err_o} !== 4'h0) begin errors++; $display("FAIL reset_rvalid got %b want 0000", {bus.r0_rvalid_o, bus.r1_rvalid_o, bus.r0_err_o, bus.r1_err_o}); end
    checks++; if ({bus.r0_rdata_o, bus.r1_rdata_o} !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", {bus.r0_rdata_o, bus.r1_rdata_o}); end
    bus.r0_req_i = 1'b0; bus.r1_req_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_contention();
    int rel;
    logic [31:0] a0 = 32'h0000_1000, a1 = 32'h0000_2004;
    @(posedge clk); #1 rst = 1'b1;
    wait_n = 0; slv_err = 1'b0; slv_data = $urandom;
    bus.r0_write_i = 1'b0; bus.r0_addr_i = a0; bus.r0_req_i = 1'b1;
    bus.r1_write_i = 1'b0; bus.r1_addr_i = a1; bus.r1_req_i = 1'b1;
    repeat (2) @(negedge clk);
    clear_logs();
    @(posedge clk); #1 rst = 1'b0; rel = cyc;
    repeat (12) @(negedge clk);
    @(posedge clk); #1 bus.r0_req_i = 1'b0; bus.r1_req_i = 1'b0;
    idle(6);
    checks++;
    if (g_cyc.size() != 4) begin errors++; $display("FAIL cont_ngnt got %0d want 4", g_cyc.size()); end
    else for (int k = 0; k < 4; k++) begin
      checks++; if (g_cyc[k] != rel + 3 * k || g_id[k] != k % 2) begin errors++; $display("FAIL cont_gnt[%0d] got r%0d@%0d want r%0d@%0d", k, g_id[k], g_cyc[k], k % 2, rel + 3 * k); end
    end
    checks++;
    if (s_addr.size() != 4 || v_cyc.size() != 4) begin errors++; $display("FAIL cont_nxfer got setups %0d rvalids %0d want 4", s_addr.size(), v_cyc.size()); end
    else for (int k = 0; k < 4; k++) begin
      checks++; if (s_addr[k] != ((k % 2) ? a1 : a0)) begin errors++; $display("FAIL cont_paddr[%0d] got %h want %h", k, s_addr[k], (k % 2) ? a1 : a0); end
      checks++; if (v_cyc[k] != rel + 3 * k + 3 || v_id[k] != k % 2 || v_data[k] != slv_data) begin errors++; $display("FAIL cont_rv[%0d] got r%0d@%0d %h want r%0d@%0d %h", k, v_id[k], v_cyc[k], v_data[k], k % 2, rel + 3 * k + 3, slv_data); end
    end
    checks++; if (inv_bad != 0) begin errors++; $display("FAIL cont_invariants got %0d violations want 0", inv_bad); end
  endtask

  task automatic test_single_read();
    do_reset();
    wait_n = 0; slv_err = 1'b0; slv_data = 32'hDEAD_BEEF;
    send(0, 1'b0, 32'h100, $urandom, 4'hF);
    idle(5);
    checks++;
    if (g_cyc.size() != 1 || s_cyc.size() != 1 || v_cyc.size() != 1) begin errors++; $display("FAIL rd_count got g%0d s%0d v%0d want 1 1 1", g_cyc.size(), s_cyc.size(), v_cyc.size()); end
    else begin
      checks++; if (s_cyc[0] != g_cyc[0] + 1 || s_addr[0] != 32'h100) begin errors++; $display("FAIL rd_setup got %h@%0d want 100@%0d", s_addr[0], s_cyc[0], g_cyc[0] + 1); end
      checks++; if (v_cyc[0] != g_cyc[0] + 3 || v_id[0] != 0) begin errors++; $display("FAIL rd_latency got r%0d@%0d want r0@%0d", v_id[0], v_cyc[0], g_cyc[0] + 3); end
      checks++; if (v_data[0] != 32'hDEAD_BEEF || v_err[0] != 1'b0) begin errors++; $display("FAIL rd_data got %h err %b want deadbeef err 0", v_data[0], v_err[0]); end
    end
  endtask

  task automatic test_wait_err();
    logic [31:0] wd = $urandom;
    logic [3:0]  st = 4'b1010;
    do_reset();
    wait_n = 4; slv_err = 1'b1; slv_data = $urandom;
    send(1, 1'b1, 32'h0000_0040, wd, st);
    idle(10);
    checks++;
    if (g_cyc.size() != 1 || s_cyc.size() != 1 || v_cyc.size() != 1) begin errors++; $display("FAIL we_count got g%0d s%0d v%0d want 1 1 1", g_cyc.size(), s_cyc.size(), v_cyc.size()); end
    else begin
      checks++; if (v_cyc[0] != g_cyc[0] + 7 || v_id[0] != 1) begin errors++; $display("FAIL we_latency got r%0d@%0d want r1@%0d", v_id[0], v_cyc[0], g_cyc[0] + 7); end
      checks++; if (v_err[0] != 1'b1 || v_data[0] != 32'h0) begin errors++; $display("FAIL we_resp got %h err %b want 0 err 1", v_data[0], v_err[0]); end
      checks++; if (s_wdata[0] != wd || s_strb[0] != st || s_wr[0] != 1'b1) begin errors++; $display("FAIL we_fields got %h/%h/%b want %h/%h/1", s_wdata[0], s_strb[0], s_wr[0], wd, st); end
    end
    checks++; if (inv_bad != 0) begin errors++; $display("FAIL we_stable got %0d violations want 0", inv_bad); end
  endtask

  task automatic test_timeout();
    do_reset();
    wait_n = 1000; slv_err = 1'b0; slv_data = $urandom;
    send(0, 1'b0, $urandom, $urandom, 4'hF);
    idle(25);
    checks++;
    if (v_cyc.size() != 1 || g_cyc.size() != 1) begin errors++; $display("FAIL to_count got g%0d v%0d want 1 1", g_cyc.size(), v_cyc.size()); end
    else begin
      checks++; if (v_cyc[0] != g_cyc[0] + 2 + TO) begin errors++; $display("FAIL to_latency got %0d want %0d", v_cyc[0], g_cyc[0] + 2 + TO); end
      checks++; if (v_err[0] != 1'b1 || v_data[0] != 32'h0 || v_psel[0] != 1'b0) begin errors++; $display("FAIL to_resp got %h err %b psel %b want 0 err 1 psel 0", v_data[0], v_err[0], v_psel[0]); end
    end
    clear_logs();
    wait_n = TO - 1; slv_err = 1'b0; slv_data = $urandom;
    send(1, 1'b0, $urandom, $urandom, 4'hF);
    idle(25);
    checks++;
    if (v_cyc.size() != 1 || g_cyc.size() != 1) begin errors++; $display("FAIL toe_count got g%0d v%0d want 1 1", g_cyc.size(), v_cyc.size()); end
    else begin
      checks++; if (v_cyc[0] != g_cyc[0] + 2 + TO || v_err[0] != 1'b0 || v_data[0] != slv_data) begin errors++; $display("FAIL toe_resp got %h err %b @%0d want %h err 0 @%0d", v_data[0], v_err[0], v_cyc[0], slv_data, g_cyc[0] + 2 + TO); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wait_n = 1000; slv_err = 1'b0; slv_data = $urandom;
    send(0, 1'b0, $urandom, $urandom, 4'hF);
    idle(4);
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.psel_o, bus.penable_o} !== 2'b00) begin errors++; $display("FAIL rm_async got %b want 00", {bus.psel_o, bus.penable_o}); end
    idle(2);
    @(posedge clk); #1 rst = 1'b0;
    idle(25);
    checks++; if (v_cyc.size() != 0) begin errors++; $display("FAIL rm_no_rvalid got %0d rvalids want 0", v_cyc.size()); end
    clear_logs();
    wait_n = 0;
    fork
      send(0, 1'b0, $urandom, $urandom, 4'hF);
      send(1, 1'b0, $urandom, $urandom, 4'hF);
    join
    idle(6);
    checks++;
    if (g_id.size() != 2 || v_cyc.size() != 2) begin errors++; $display("FAIL rm_tie_count got g%0d v%0d want 2 2", g_id.size(), v_cyc.size()); end
    else begin
      checks++; if (g_id[0] != 0 || g_id[1] != 1) begin errors++; $display("FAIL rm_tie got r%0d,r%0d want r0,r1", g_id[0], g_id[1]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wait_n = 2; slv_err = 1'b0; slv_data = $urandom;
    fork
      send(0, 1'b0, $urandom, $urandom, 4'hF);
      begin idle(2); send(1, 1'b1, $urandom, $urandom, 4'h3); end
    join
    idle(12);
    checks++;
    if (g_cyc.size() != 2 || v_cyc.size() != 2) begin errors++; $display("FAIL b2b_count got g%0d v%0d want 2 2", g_cyc.size(), v_cyc.size()); end
    else begin
      checks++; if (g_id[1] != 1 || v_id[0] != 0 || g_cyc[1] != v_cyc[0]) begin errors++; $display("FAIL b2b_gnt got r%0d gnt@%0d want r1 gnt@%0d", g_id[1], g_cyc[1], v_cyc[0]); end
      checks++; if (v_id[1] != 1 || v_cyc[1] != g_cyc[1] + 5) begin errors++; $display("FAIL b2b_rv got r%0d@%0d want r1@%0d", v_id[1], v_cyc[1], g_cyc[1] + 5); end
    end
  endtask

  task automatic test_random();
    int m_last = 1;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      logic        r_wr[2];
      logic [31:0] r_a[2];
      logic [31:0] r_wd[2];
      logic [3:0]  r_st[2];
      int          e_id[2];
      int          n, w, lat, id;
      logic        both;
      logic [31:0] e_data;
      logic        e_err;
      for (int r = 0; r < 2; r++) begin
        r_wr[r] = 1'($urandom); r_a[r] = $urandom; r_wd[r] = $urandom; r_st[r] = 4'($urandom);
      end
      w    = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(0, 5);
      lat  = (w < TO) ? 3 + w : 2 + TO;
      both = ($urandom_range(0, 2) == 0);
      id   = $urandom_range(0, 1);
      wait_n = w; slv_err = 1'($urandom); slv_data = $urandom;
      clear_logs();
      if (both) begin
        n = 2; e_id[0] = (m_last == 1) ? 0 : 1; e_id[1] = m_last;
        fork
          send(0, r_wr[0], r_a[0], r_wd[0], r_st[0]);
          send(1, r_wr[1], r_a[1], r_wd[1], r_st[1]);
        join
      end else begin
        n = 1; e_id[0] = id; m_last = id;
        send(id, r_wr[id], r_a[id], r_wd[id], r_st[id]);
      end
      idle(lat + 3);
      checks++;
      if (g_cyc.size() != n || v_cyc.size() != n || s_addr.size() != n) begin
        errors++; $display("FAIL rnd%0d_count got g%0d s%0d v%0d want %0d", it, g_cyc.size(), s_addr.size(), v_cyc.size(), n);
      end else begin
        for (int k = 0; k < n; k++) begin
          e_data = (w < TO && !r_wr[e_id[k]]) ? slv_data : 32'h0;
          e_err  = (w < TO) ? slv_err : 1'b1;
          checks++; if (g_id[k] != e_id[k] || v_id[k] != e_id[k] || v_cyc[k] != g_cyc[k] + lat) begin errors++; $display("FAIL rnd%0d_order[%0d] got gnt r%0d rv r%0d@+%0d want r%0d@+%0d", it, k, g_id[k], v_id[k], v_cyc[k] - g_cyc[k], e_id[k], lat); end
          checks++; if (v_data[k] != e_data || v_err[k] != e_err) begin errors++; $display("FAIL rnd%0d_resp[%0d] got %h err %b want %h err %b", it, k, v_data[k], v_err[k], e_data, e_err); end
          checks++; if ({s_addr[k], s_wdata[k], s_wr[k], s_strb[k]} != {r_a[e_id[k]], r_wd[e_id[k]], r_wr[e_id[k]], r_st[e_id[k]]}) begin errors++; $display("FAIL rnd%0d_fields[%0d] got %h/%h/%b/%h want %h/%h/%b/%h", it, k, s_addr[k], s_wdata[k], s_wr[k], s_strb[k], r_a[e_id[k]], r_wd[e_id[k]], r_wr[e_id[k]], r_st[e_id[k]]); end
        end
        if (n == 2) begin
          checks++; if (g_cyc[1] != v_cyc[0]) begin errors++; $display("FAIL rnd%0d_b2b got gnt@%0d want @%0d", it, g_cyc[1], v_cyc[0]); end
        end
      end
      checks++; if (inv_bad != 0) begin errors++; $display("FAIL rnd%0d_invariants got %0d violations want 0", it, inv_bad); end
    end
  endtask

  initial begin
    bus.r0_req_i = 1'b0; bus.r0_write_i = 1'b0; bus.r0_addr_i = '0; bus.r0_wdata_i = '0; bus.r0_strb_i = '0;
    bus.r1_req_i = 1'b0; bus.r1_write_i = 1'b0; bus.r1_addr_i = '0; bus.r1_wdata_i = '0; bus.r1_strb_i = '0;
    test_reset();
    test_contention();
    test_single_read();
    test_wait_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
